my_32bit_pipelined_leftshifter: RTL
===================================

# my_32bit_pipelined_leftshifter

Five-stage pipelined 32-bit logical left shifter with valid/ready handshakes on both sides. It is the left-shift counterpart to the combinational 32-bit barrel right shifter and serves the execute stage for `sll`. Each pipeline stage applies one power-of-two shift (16, 8, 4, 2, 1), so timing closes at full clock rate. An opaque tag travels with each operation so the consumer can match results to instructions.

## Interface
Parameters:
- `TAG_W`, default 5: width of the tag carried alongside each operation (e.g. destination register).

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; clears all stage valids.
- `in_valid`  in  1  an operation is offered.
- `in_ready`  out  1  stage 0 can accept this cycle.
- `in_data`  in  32  operand to shift.
- `in_shamt`  in  5  shift amount, 0–31.
- `in_tag`  in  TAG_W  opaque tag.
- `out_valid`  out  1  result available in stage 4.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  32  `in_data << in_shamt`, zero-filled.
- `out_tag`  out  TAG_W  tag of the result.

## Operation
- Stage k (k = 0..4) registers `valid_k`, `data_k`, `shamt_k`, and `tag_k`.
- Stage 0 loads `in_data << 16` if `in_shamt[4]` is set, otherwise `in_data` unchanged.
- Stages 1, 2, 3, and 4 shift the previous stage's data by 8, 4, 2, and 1 under `shamt[3]`, `shamt[2]`, `shamt[1]`, and `shamt[0]` respectively.
- Fill is logical: vacated LSBs are always 0, and bits shifted past bit 31 are discarded.
- Shift amount 0 passes data through unchanged.
- Advance rule: `adv_4 = out_ready | ~valid_4`. For k < 4, `adv_k = adv_{k+1} | ~valid_k`.
- `in_ready = adv_0`.
- When `adv_k` is high, stage k loads from its upstream stage (stage 0 loads from the inputs), and `valid_k` takes the upstream valid.
- When `adv_k` is low, stage k holds all of its registers.
- `out_valid = valid_4`. `out_data` and `out_tag` come from stage 4 and are held stable while `out_valid & ~out_ready`.
- Input acceptance happens on cycles where `in_valid & in_ready`. Input fields are ignored when `in_valid` is low, and stage 0 then loads a bubble.
- Operations never reorder, merge, or drop, except on reset.
- Invalid stages may carry stale data. `out_data`/`out_tag` are don't-care when `out_valid` is low.

## Timing
- Reset: all `valid_k` = 0 and all data/tag/shamt registers = 0. Consequently `out_valid` = 0, `out_data` = 0, `out_tag` = 0, and `in_ready` = 1 in the first cycle after reset.
- Reset mid-operation: all in-flight operations are discarded. `reset` overrides any simultaneous handshake, so an input offered in the reset cycle is not accepted.
- Latency: an operation accepted at edge N appears with `out_valid` = 1 after edge N+4 (5 register stages), assuming no stalls.
- Throughput: one operation per cycle while `out_ready` is held high.
- Backpressure: while `out_ready` is low, bubbles collapse. Up to 5 operations are buffered, and `in_ready` falls only once all 5 stages are valid.
- Simultaneous events: if the pipeline is full and the consumer pops, then `in_ready` = 1 in that same cycle (combinational ready chain), and the whole pipe shifts by one. No cycle is lost.
- There is no combinational path from `in_valid` to `out_valid`. The only combinational outputs are `in_ready`, which depends on `out_ready` and the valids.

## Structure
- Shared package `shifter_pkg`:
  - `DATA_W` = 32.
  - `SHAMT_W` = 5.
  - `NUM_STAGES` = 5.
  - Per-stage shift constants 16/8/4/2/1, indexed by stage.
- One sub-module, `my_leftshift_stage`:
  - Parameter `SHIFT`.
  - Registered valid/data/shamt/tag with the advance rule above.
  - Instantiated five times, with stage k using `shamt[4-k]`.
  - The top level contains only instantiation and the ready chain.

## Test plan
- Basic latency: reset, then a single op with data 0x00000001, shamt 31, tag 3 → exactly 5 cycles later `out_valid` = 1, `out_data` = 0x80000000, `out_tag` = 3. `out_valid` = 0 in every cycle before that.
- Back-to-back: with `out_ready` held at 1, send 0x12345678 with shamt 0, 4, 16, 31 on consecutive cycles. Required results, in order, on consecutive cycles: 0x12345678, 0x23456780, 0x56780000, 0x00000000.
- Backpressure: send 0xFFFFFFFF with shamt 1..6 while `out_ready` = 0.
  - `in_ready` must drop after the 5th acceptance.
  - Outputs must stay stable at 0xFFFFFFFE.
  - After `out_ready` rises, results follow in order: 0xFFFFFFFE, 0xFFFFFFFC, 0xFFFFFFF8, 0xFFFFFFF0, 0xFFFFFFE0, 0xFFFFFFC0.
  - No loss or duplication.
- Full-pipe pop with simultaneous input: with the pipe full and `in_valid` = 1, pulse `out_ready` for one cycle → exactly one result retires, the new op is accepted the same cycle, and occupancy stays 5.
- Reset mid-flight: accept 3 ops, then assert `reset` for 1 cycle → `out_valid` = 0 with no stale result. The next op has a clean 5-cycle latency.
- Random: 10k random data/shamt/tag values with random `in_valid`/`out_ready`, compared against the reference model `(data << shamt) & 0xFFFFFFFF` with in-order tags.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared constants for the pipelined left shifter: datapath widths, stage count
// and the per-stage shift distances.
package shifter_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SHAMT_W    = 5;
  localparam int unsigned NUM_STAGES = 5;

  // Stage k shifts by 2^(NUM_STAGES-1-k): 16, 8, 4, 2, 1.
  function automatic int unsigned stage_shift(input int unsigned k);
    return 32'd1 << (NUM_STAGES - 1 - k);
  endfunction

  // Shift-amount bit that enables stage k.
  function automatic int unsigned stage_sel_bit(input int unsigned k);
    return NUM_STAGES - 1 - k;
  endfunction

endpackage

// File: rtl/my_leftshift_stage.sv
// One pipeline stage: optionally shifts left by SHIFT and registers
// valid/data/shamt/tag, loading from upstream only when allowed to advance.
module my_leftshift_stage
  import shifter_pkg::*;
#(
  parameter int unsigned SHIFT   = 1,
  parameter int unsigned SEL_BIT = 0,
  parameter int unsigned TAG_W   = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               adv_i,
  input  logic               up_valid_i,
  input  logic [DATA_W-1:0]  up_data_i,
  input  logic [SHAMT_W-1:0] up_shamt_i,
  input  logic [TAG_W-1:0]   up_tag_i,
  output logic               valid_o,
  output logic [DATA_W-1:0]  data_o,
  output logic [SHAMT_W-1:0] shamt_o,
  output logic [TAG_W-1:0]   tag_o
);

  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  data_q,  data_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [TAG_W-1:0]   tag_q,   tag_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    tag_d   = tag_q;
    if (adv_i) begin
      // Payload loads even for a bubble; stale data in invalid stages is harmless.
      valid_d = up_valid_i;
      data_d  = up_shamt_i[SEL_BIT] ? (up_data_i << SHIFT) : up_data_i;
      shamt_d = up_shamt_i;
      tag_d   = up_tag_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      tag_q   <= tag_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign shamt_o = shamt_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/my_32bit_pipelined_leftshifter.sv
// Five-stage 32-bit logical left shifter with valid/ready on both sides;
// a combinational ready chain lets bubbles collapse under backpressure.
module my_32bit_pipelined_leftshifter
  import shifter_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [TAG_W-1:0]   out_tag
);

  logic [NUM_STAGES-1:0] valid_s;
  logic [NUM_STAGES-1:0] adv_s;
  logic [DATA_W-1:0]     data_s  [NUM_STAGES];
  logic [SHAMT_W-1:0]    shamt_s [NUM_STAGES];
  logic [TAG_W-1:0]      tag_s   [NUM_STAGES];

  // A stage may advance if it is empty or the stage after it advances.
  always_comb begin
    adv_s = '0;
    adv_s[NUM_STAGES-1] = out_ready | ~valid_s[NUM_STAGES-1];
    for (int unsigned i = 1; i < NUM_STAGES; i++) begin
      adv_s[NUM_STAGES-1-i] = adv_s[NUM_STAGES-i] | ~valid_s[NUM_STAGES-1-i];
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic               up_valid;
    logic [DATA_W-1:0]  up_data;
    logic [SHAMT_W-1:0] up_shamt;
    logic [TAG_W-1:0]   up_tag;

    if (k == 0) begin : g_src_in
      assign up_valid = in_valid;
      assign up_data  = in_data;
      assign up_shamt = in_shamt;
      assign up_tag   = in_tag;
    end else begin : g_src_prev
      assign up_valid = valid_s[k-1];
      assign up_data  = data_s[k-1];
      assign up_shamt = shamt_s[k-1];
      assign up_tag   = tag_s[k-1];
    end

    my_leftshift_stage #(
      .SHIFT   (stage_shift(k)),
      .SEL_BIT (stage_sel_bit(k)),
      .TAG_W   (TAG_W)
    ) u_stage (
      .clock      (clock),
      .reset      (reset),
      .adv_i      (adv_s[k]),
      .up_valid_i (up_valid),
      .up_data_i  (up_data),
      .up_shamt_i (up_shamt),
      .up_tag_i   (up_tag),
      .valid_o    (valid_s[k]),
      .data_o     (data_s[k]),
      .shamt_o    (shamt_s[k]),
      .tag_o      (tag_s[k])
    );
  end

  // The last stage's shift amount has no consumer.
  logic [SHAMT_W-1:0] unused_shamt;
  assign unused_shamt = shamt_s[NUM_STAGES-1];

  assign in_ready  = adv_s[0];
  assign out_valid = valid_s[NUM_STAGES-1];
  assign out_data  = data_s[NUM_STAGES-1];
  assign out_tag   = tag_s[NUM_STAGES-1];

endmodule
